// File: rtl/isrd.sv
// Iterative AES-128 inverse SubBytes: LANES inverse S-boxes walk the 16-byte
// state over 16/LANES cycles; is_last bypasses substitution entirely.

module isrd_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8) (0 maps to 0); built from the squares x^2..x^128
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gmul(x, x);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    assign dout = ginv(inv_affine(din));
endmodule

module isrd #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [128:1] cipher_t,
    input  logic         ok_t,
    input  logic         is_last,
    output logic [128:1] cipher_sub,
    output logic         ok_sub,
    output logic         busy
);
    localparam int K  = 16 / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, SUB, DONE} st_t;

    st_t                   state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [15:0][7:0]      wk, wk_nxt;
    logic [LANES-1:0][7:0] lane_in, lane_out;
    logic                  ld_out;

    function automatic logic [3:0] bidx(input logic [CW-1:0] c, input int l);
        return 4'(int'(c) * LANES + l);
    endfunction

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) lane_in[l] = wk[bidx(cnt, l)];
    end

    isrd_lane u_lane [LANES-1:0] (.din(lane_in), .dout(lane_out));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wk_nxt    = wk;
        ld_out    = 1'b0;
        case (state)
            IDLE: if (ok_t) begin
                wk_nxt    = cipher_t;
                cnt_nxt   = '0;
                state_nxt = is_last ? DONE : SUB;
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) wk_nxt[bidx(cnt, l)] = lane_out[l];
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(K - 1)) state_nxt = DONE;
            end
            DONE: begin
                ld_out = 1'b1;
                // back-to-back: a new state may be taken on the delivering edge
                if (ok_t) begin
                    wk_nxt    = cipher_t;
                    cnt_nxt   = '0;
                    state_nxt = is_last ? DONE : SUB;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wk         <= '0;
            cipher_sub <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wk    <= wk_nxt;
            if (ld_out) cipher_sub <= wk;
        end
    end

    assign ok_sub = (state == DONE);
    assign busy   = (state == SUB);
endmodule
